// File: rtl/servo_pwm_slew.sv
// servo_pwm_slew: four-channel servo PWM with slew-limited position stepping once per frame
module servo_pwm_slew #(
    parameter int NCH = 4,
    parameter int BASE_W = 100000,
    parameter int STEP_W = 392
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [19:0]    count,
    input  logic           wr_en,
    input  logic [1:0]     wr_ch,
    input  logic [7:0]     wr_target,
    input  logic [7:0]     wr_rate,
    input  logic [NCH-1:0] en,
    output logic [NCH-1:0] pwm,
    output logic [NCH-1:0] at_target
);
    logic [7:0]        target [NCH];
    logic [7:0]        rate [NCH];
    logic [7:0]        cur [NCH];
    logic [7:0]        cur_nx [NCH];
    logic signed [8:0] d [NCH];
    logic [8:0]        mag [NCH];
    logic [17:0]       width_q [NCH];
    logic [17:0]       width_nx [NCH];
    logic [NCH-1:0]    en_q;
    logic [NCH-1:0]    en_nx;
    logic              frame;
    logic              latch;
    assign frame = count == 20'd0;
    assign latch = count == 20'd1;
    // the frame-start cycle already drives the new enable so no pulse loses its first count
    assign en_nx = frame ? en : en_q;
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            d[i] = $signed({1'b0, target[i]}) - $signed({1'b0, cur[i]});
            mag[i] = d[i][8] ? 9'(-d[i]) : 9'(d[i]);
            cur_nx[i] = (rate[i] == 8'd0 || mag[i] <= {1'b0, rate[i]}) ? target[i] :
                        d[i][8] ? cur[i] - rate[i] : cur[i] + rate[i];
            width_nx[i] = 18'(BASE_W + STEP_W * int'(cur[i]));
        end
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                target[i] <= 8'd128;
                rate[i] <= 8'd0;
                cur[i] <= 8'd128;
                width_q[i] <= 18'(BASE_W + STEP_W * 128);
            end
            en_q <= '0;
            pwm <= '0;
            at_target <= {NCH{1'b1}};
        end else begin
            en_q <= en_nx;
            for (int i = 0; i < NCH; i++) begin
                if (frame)
                    cur[i] <= cur_nx[i];
                if (latch)
                    width_q[i] <= width_nx[i];
                pwm[i] <= en_nx[i] && (count < {2'b00, width_q[i]});
                at_target[i] <= cur[i] == target[i];
            end
            if (wr_en) begin
                target[wr_ch] <= wr_target;
                rate[wr_ch] <= wr_rate;
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_slew.sv
// tb_servo_pwm_slew: directed bench with a width scoreboard fed by a per-channel slew model
module tb_servo_pwm_slew;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [19:0] count = 20'd500;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = 2'd0;
    logic [7:0]  wr_target = 8'd0;
    logic [7:0]  wr_rate = 8'd0;
    logic [3:0]  en = 4'h0;
    logic [3:0]  pwm;
    logic [3:0]  at_target;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int m_tgt[4];
    int m_rate[4];
    int m_cur[4];
    logic [3:0] m_en;

    servo_pwm_slew dut (
        .clk(clk), .clr(clr), .count(count), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_target(wr_target), .wr_rate(wr_rate), .en(en), .pwm(pwm), .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] m_at();
        logic [3:0] a;
        for (int c = 0; c < 4; c++) a[c] = m_cur[c] == m_tgt[c];
        return a;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_tgt[c] = 128;
            m_cur[c] = 128;
            m_rate[c] = 0;
        end
        m_en = 4'h0;
        exp_q.delete();
    endtask

    task automatic model_step();
        for (int c = 0; c < 4; c++) begin
            int dd;
            dd = m_tgt[c] - m_cur[c];
            if (m_rate[c] == 0 || (dd < 0 ? -dd : dd) <= m_rate[c]) m_cur[c] = m_tgt[c];
            else m_cur[c] = m_cur[c] + (dd > 0 ? m_rate[c] : -m_rate[c]);
            exp_q.push_back(100000 + m_cur[c] * 392);
        end
        m_en = en;
    endtask

    task automatic wr(input int ch, input int t, input int r);
        wr_en = 1'b1;
        wr_ch = 2'(ch);
        wr_target = 8'(t);
        wr_rate = 8'(r);
        tick();
        wr_en = 1'b0;
        m_tgt[ch] = t;
        m_rate[ch] = r;
    endtask

    task automatic frame_start(input bit w = 1'b0, input int ch = 0, input int t = 0, input int r = 0);
        count = 20'd0;
        if (w) begin
            wr_en = 1'b1;
            wr_ch = 2'(ch);
            wr_target = 8'(t);
            wr_rate = 8'(r);
        end
        tick();
        wr_en = 1'b0;
        model_step();
        if (w) begin
            m_tgt[ch] = t;
            m_rate[ch] = r;
        end
        chk("pwm_count0", pwm, m_en);
        count = 20'd1;
        tick();
    endtask

    task automatic check_frame();
        chk("at_target", at_target, m_at());
        for (int c = 0; c < 4; c++) begin
            int w;
            w = exp_q.pop_front();
            count = 20'(w - 1);
            tick();
            chk($sformatf("pwm%0d_last_high w=%0d", c, w), {3'b000, pwm[c]}, {3'b000, m_en[c]});
            count = 20'(w);
            tick();
            chk($sformatf("pwm%0d_first_low w=%0d", c, w), {3'b000, pwm[c]}, 4'h0);
        end
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        clr = 1'b0;
        chk("reset_pwm", pwm, 4'h0);
        chk("reset_at", at_target, 4'hF);
        en = 4'hF;
        frame_start();
        check_frame();

        wr(0, 0, 0);
        tick();
        chk("write_drops_at", at_target, m_at());
        frame_start();
        check_frame();
        wr(0, 255, 0);
        frame_start();
        check_frame();

        wr(1, 140, 5);
        for (int k = 0; k < 3; k++) begin
            frame_start();
            check_frame();
        end
        wr(1, 0, 60);
        for (int k = 0; k < 3; k++) begin
            frame_start();
            check_frame();
        end

        frame_start(1'b1, 2, 0, 0);
        check_frame();
        frame_start();
        check_frame();

        count = 20'd120000;
        en = 4'h7;
        tick();
        chk("en_midframe_pwm3", {3'b000, pwm[3]}, {3'b000, m_en[3]});
        frame_start();
        check_frame();
        en = 4'hF;
        frame_start();
        check_frame();

        count = 20'd500;
        wr(0, 10, 3);
        wr(1, 200, 0);
        wr(2, 50, 20);
        wr(3, 255, 100);
        tick();
        chk("interleave_at", at_target, m_at());
        for (int k = 0; k < 3; k++) begin
            frame_start();
            check_frame();
        end

        count = 20'd160000;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_reset();
        chk("midframe_reset_pwm", pwm, 4'h0);
        chk("midframe_reset_at", at_target, 4'hF);
        frame_start();
        check_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/servo_pwm_slew.md
# servo_pwm_slew

Four-channel servo pulse generator for the PmodCON3 path, sitting directly downstream of the 10 ms frame counter: it consumes the free-running 20-bit `count` (0..1000000, 100 MHz) and produces one PWM line per servo. Software writes an 8-bit target position and slew rate per channel. Once per frame, the block moves each channel's current position toward its target by at most the rate. The pulse width is latched per frame, so pulses never glitch mid-frame.

## Interface
Parameters:
- `NCH`, 4, number of servo channels (channel index width fixed at 2 bits).
- `BASE_W`, 100000, pulse width in cycles at position 0 (1.0 ms).
- `STEP_W`, 392, cycles per position LSB (position 255 gives 199960 cycles).

Ports:
- `clk` in 1: 100 MHz system clock.
- `clr` in 1: reset, synchronous and active-high.
- `count` in 20: frame counter value. Counts 0..1000000 and wraps to 0.
- `wr_en` in 1: one-cycle write strobe.
- `wr_ch` in 2: channel index for the write.
- `wr_target` in 8: target position, 0..255.
- `wr_rate` in 8: maximum position change per frame. 0 means jump directly to the target.
- `en` in NCH: per-channel output enable, sampled at frame start.
- `pwm` out NCH: servo pulse outputs, registered.
- `at_target` out NCH: high when the channel's current position equals its target, registered.

## Operation
Per-channel registers:
- `target`, `rate`, `cur`, `width_q` (18 bits), `en_q`.

Reset (`clr`=1 at a clock edge), all values visible the following cycle:
- `target`=128, `cur`=128, `rate`=0.
- `width_q`=150176.
- `en_q`=0, `pwm`=0, `at_target`=all ones.
- Reset mid-frame takes effect at the next edge, regardless of `count`.

Write:
- On `wr_en`=1, `target[wr_ch]` and `rate[wr_ch]` load at the edge.
- No handshake; the block accepts a write every cycle.
- Writes to other channels are unaffected.

Frame start (cycle where sampled `count`==0):
- `en_q <= en`.
- For each channel, with d = `target` − `cur`:
  - `rate`==0 or |d| ≤ `rate`: `cur <= target`.
  - Otherwise `cur` moves toward the target by exactly `rate`.
- Arithmetic is 9-bit signed, so `cur` can never wrap past 0 or 255.
- If a write coincides with the count==0 cycle, the step uses the pre-write `target`/`rate`. The new values apply from the next frame.

Width latch (cycle where sampled `count`==1):
- `width_q <= BASE_W + cur*STEP_W`, computed from the `cur` updated at count==0.
- Multiply by constant, ≥18-bit result, no truncation.

PWM, every cycle:
- `pwm[i] <= en_q[i] && (count < width_q[i])`.
- `count` values in 0..1 compare against the previous `width_q`. Both are < BASE_W, so the output is identical either way.
- The pulse is high for exactly `width_q` consecutive counts per frame, starting at count 0.
- With `en_q`=0 the output is low for the whole frame.
- Changing `en` mid-frame has no effect until the next frame start.

`at_target[i] <= (cur[i] == target[i])`, updated every cycle.

## Timing
- Output `pwm` lags `count` by one cycle: rising edge the cycle after count==0, falling edge the cycle after count==`width_q`.
- Frame period 1000001 cycles; pulse width range 100000..199960 cycles.
- Write to first affected pulse: the next frame start whose count==0 cycle is after the write cycle.
- Slew time from a to b is ceil(|b−a| / rate) frames.
- `at_target` rises one cycle after the frame-start edge that makes `cur`==`target`.
- A write making `target`≠`cur` drops `at_target` one cycle after the write.
- `count` is assumed monotonic with wrap. Any jump back to 0, including an external counter clear, is treated as a frame start.

## Test plan
- **Reset:** assert `clr` mid-frame → next cycle `pwm`=0, `at_target`=4'hF. After `en`=4'hF and a frame start, every channel's pulse is 150176 cycles.
- **Jump:** write ch0 target=0, rate=0 → next frame ch0 pulse = 100000 cycles. Write target=255 → next frame pulse = 199960. `at_target[0]` is high after each of those frame starts.
- **Slew:** ch1 cur=128, write target=140, rate=5 → successive pulses 152136, 154096, 154880. `at_target[1]` rises after the third frame start. Symmetric downward check to target=0, with last step clamped.
- **Boundary write:** assert `wr_en` exactly on the count==0 cycle with target=0 for ch2 → that frame still uses the old width; the change appears one frame later.
- **Enable:** toggle `en[3]` at count=120000 → the current frame is unchanged. The next frame's `pwm[3]` follows the new `en`, and no partial pulses occur.
- **Independence:** interleave back-to-back writes to all four channels on consecutive cycles → each channel gets its own target/rate, and pulses match the expected widths.
